// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART transmit arbiter slice.
//   arb_state_t : arbiter FSM states, one per phase of moving a byte
//                 from a requester into the UART transmitter.
//   UART_DATA_W : width of one UART payload byte.
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      START     = 3'd2,
      WAIT_ACK  = 3'd3,
      WAIT_DONE = 3'd4,
      RELEASE   = 3'd5
   } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin priority encoder. Returns the first set bit
//   of req_i, searching from position ptr_i upwards and wrapping modulo
//   N_REQ.
//   req_i  : request vector
//   ptr_i  : position with highest priority (must be < N_REQ)
//   pick_o : one-hot winner, all zero when req_i is zero
//   idx_o  : index of the winner (zero when req_i is zero)
// ---------------------------------------------------------------------------
module rr_picker #(
   parameter int N_REQ = 3,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] pick_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [N_REQ-1:0] rot;
   logic [IDX_W:0]   sum;

   always_comb begin
      // Rotate so that ptr_i lands on bit 0; the lowest set bit of rot is
      // then the winner, and its offset is added back to ptr_i.
      rot = N_REQ'({req_i, req_i} >> ptr_i);
      sum = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
         end
      end
      if (sum >= (IDX_W+1)'(N_REQ)) begin
         sum = sum - (IDX_W+1)'(N_REQ);
      end
      idx_o  = sum[IDX_W-1:0];
      pick_o = (|req_i) ? (N_REQ'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter among N_REQ byte-stream requesters with
//   packet-granular round-robin arbitration. The owner keeps the
//   transmitter until a byte flagged last has been sent.
//
//   Requester handshake: requester i offers a byte by holding req_valid[i]
//   with req_data/req_last stable; the byte is consumed on the clock edge
//   at which req_ready[i] is high (req_ready is only ever high for the
//   current owner, during LOAD, and only while its req_valid is high).
//
//   Ports
//   clk, rst        : clock, synchronous active-low reset
//   req_valid/data/last, req_ready : per-requester byte interface
//   tx_start, tx_data, tx_busy     : UART transmitter interface
//   grant           : one-hot current owner, zero when idle
//   err_timeout     : sticky, tx_busy did not rise after a tx_start
//   state_o         : FSM state (debug)
//   rr_ptr_o        : round-robin pointer (debug)
// ---------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ       = 3,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [UART_DATA_W*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]             req_last,
   output logic [N_REQ-1:0]             req_ready,
   output logic                         tx_start,
   output logic [UART_DATA_W-1:0]       tx_data,
   input  logic                         tx_busy,
   output logic [N_REQ-1:0]             grant,
   output logic                         err_timeout,
   output logic [2:0]                   state_o,
   output logic [$clog2(N_REQ)-1:0]     rr_ptr_o
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

   arb_state_t             state_q, state_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [N_REQ-1:0]       grant_q, grant_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [UART_DATA_W-1:0] data_q, data_d;
   logic                   last_q, last_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;

   logic [N_REQ-1:0]       pick;
   logic [IDX_W-1:0]       pick_idx;
   logic [UART_DATA_W-1:0] owner_data;
   logic                   owner_last;
   logic                   owner_valid;
   logic [IDX_W-1:0]       next_ptr;

   rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i  (req_valid),
      .ptr_i  (rr_ptr_q),
      .pick_o (pick),
      .idx_o  (pick_idx)
   );

   // Byte lane of the current owner.
   always_comb begin
      owner_data  = '0;
      owner_last  = 1'b0;
      owner_valid = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_q == IDX_W'(i)) begin
            owner_data  = req_data[UART_DATA_W*i +: UART_DATA_W];
            owner_last  = req_last[i];
            owner_valid = req_valid[i];
         end
      end
   end

   // Priority moves to the requester after the one just served.
   assign next_ptr = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      data_d    = data_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      req_ready = '0;
      tx_start  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               owner_d = pick_idx;
               grant_d = pick;
               state_d = LOAD;
            end
         end
         LOAD: begin
            // Grant is held while the owner stalls between bytes.
            if (owner_valid) begin
               data_d    = owner_data;
               last_d    = owner_last;
               req_ready = grant_q;
               state_d   = START;
            end
         end
         START: begin
            tx_start = 1'b1;
            cnt_d    = '0;
            state_d  = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 2)) begin
               // The counter would reach ACK_TIMEOUT-1 this cycle, so
               // err_timeout rises ACK_TIMEOUT cycles after tx_start.
               err_d    = 1'b1;
               grant_d  = '0;
               rr_ptr_d = next_ptr;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = last_q ? RELEASE : LOAD;
            end
         end
         RELEASE: begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         data_q   <= data_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   assign tx_data     = data_q;
   assign grant       = grant_q;
   assign err_timeout = err_q;
   assign state_o     = state_q;
   assign rr_ptr_o    = rr_ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Bench for uart_tx_arbiter. Requesters are fed from per-requester byte
//   queues; a packet-level round-robin model predicts the sequence of
//   (owner, byte) pairs that must appear at tx_start.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int N      = 3;
   localparam int ACK_TO = 16;
   localparam int EW     = 12;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           tx_start;
   logic [7:0]     tx_data;
   logic           tx_busy;
   logic [N-1:0]   grant;
   logic           err_timeout;
   logic [2:0]     dbg_state;
   logic [1:0]     dbg_rr;

   uart_tx_arbiter #(
      .N_REQ       (N),
      .ACK_TIMEOUT (ACK_TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .grant       (grant),
      .err_timeout (err_timeout),
      .state_o     (dbg_state),
      .rr_ptr_o    (dbg_rr)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: observed no end of test, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- counters / checker ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int n_starts = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- stimulus state ----------------
   logic [8:0]    src_q [N][$];   // bytes still to be offered, {last, data}
   logic [8:0]    mdl_q [N][$];   // model copy of the same packets
   logic [EW-1:0] exp_q [$];      // expected {owner, byte} at each tx_start
   int            m_ptr;          // model round-robin pointer
   int            stall [N];
   int            stall_fixed = -1;
   int            stall_max   = 3;
   bit            uart_on     = 1'b1;
   int            dly_max     = 3;
   int            busy_min    = 2;
   int            busy_max    = 8;
   logic [N-1:0]  took;

   // ---------------- requester driver ----------------
   initial begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      for (int i = 0; i < N; i++) stall[i] = 0;
      forever begin
         @(negedge clk);
         took = req_ready & req_valid;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (took[i] && src_q[i].size() > 0) begin
               logic [8:0] b;
               b = src_q[i].pop_front();
               if (!b[8]) stall[i] = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(stall_max, 0));
               else stall[i] = 0;
            end
            if (stall[i] > 0) begin
               req_valid[i] = 1'b0;
               stall[i]--;
            end else if (src_q[i].size() > 0) begin
               logic [8:0] h;
               h = src_q[i][0];
               req_valid[i]       = 1'b1;
               req_data[8*i +: 8] = h[7:0];
               req_last[i]        = h[8];
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   // ---------------- UART model ----------------
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && tx_start && uart_on) begin
            repeat ($urandom_range(dly_max, 0)) @(negedge clk);
            tx_busy = 1'b1;
            repeat ($urandom_range(busy_max, busy_min)) @(negedge clk);
            tx_busy = 1'b0;
         end
      end
   end

   // ---------------- scoreboard / monitor ----------------
   logic [7:0] last_tx;
   logic       prev_busy = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         if (tx_start) begin
            int gi;
            gi = 0;
            for (int k = 0; k < N; k++) if (grant[k]) gi = k;
            n_starts++;
            check_val("grant_onehot_at_start", $onehot(grant), 1);
            check_val("start_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_val("start_owner_byte", {4'(gi), tx_data}, exp_q.pop_front());
            last_tx = tx_data;
         end
         if (req_ready != '0) begin
            check_val("ready_eq_grant", req_ready, grant);
            check_val("ready_with_valid", req_ready & req_valid, req_ready);
         end
         if (prev_busy && !tx_busy && grant != '0) check_val("tx_data_hold", tx_data, last_tx);
      end
      prev_busy = tx_busy;
   end

   // ---------------- helpers ----------------
   task automatic add_byte(input int r, input logic [7:0] d, input logic lst);
      src_q[r].push_back({lst, d});
      mdl_q[r].push_back({lst, d});
   endtask

   // Whole-packet round-robin: serve the first requester with a pending
   // packet starting at the pointer, emit the full packet, move past it.
   task automatic model_run();
      bit more;
      more = 1'b1;
      while (more) begin
         int o;
         o = -1;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (o < 0 && mdl_q[c].size() > 0) o = c;
         end
         if (o < 0) begin
            more = 1'b0;
         end else begin
            bit done;
            done = 1'b0;
            while (!done && mdl_q[o].size() > 0) begin
               logic [8:0] b;
               b = mdl_q[o].pop_front();
               exp_q.push_back({4'(o), b[7:0]});
               done = b[8];
            end
            m_ptr = (o + 1) % N;
         end
      end
   endtask

   function automatic bit all_src_empty();
      for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clear_all();
      for (int k = 0; k < N; k++) begin
         src_q[k].delete();
         mdl_q[k].delete();
         stall[k] = 0;
      end
      exp_q.delete();
      m_ptr = 0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_all();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int  cyc;
      bit  done;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < budget) begin
         @(negedge clk);
         cyc++;
         done = exp_q.size() == 0 && grant == '0 && !tx_busy && all_src_empty() && req_valid == '0;
      end
      check_val({tag, "_completes"}, done, 1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int s0;
      int cnt;
      bit seen;
      rst = 1'b0;
      m_ptr = 0;
      do_reset();

      // reset state
      check_val("rst_grant", grant, 0);
      check_val("rst_req_ready", req_ready, 0);
      check_val("rst_tx_start", tx_start, 0);
      check_val("rst_tx_data", tx_data, 0);
      check_val("rst_err", err_timeout, 0);
      check_val("rst_rr_ptr", dbg_rr, 0);
      check_val("rst_state", dbg_state, 32'(IDLE));

      // single packet from requester 1, 10-cycle busy
      dly_max = 0; busy_min = 10; busy_max = 10;
      s0 = n_starts;
      add_byte(1, 8'h6A, 1'b0);
      add_byte(1, 8'h55, 1'b1);
      model_run();
      wait_idle("single", 400);
      check_val("single_starts", n_starts - s0, 2);
      check_val("single_grant_after", grant, 0);
      check_val("single_rr_ptr", dbg_rr, m_ptr);

      // contention: all three with one-byte packets
      dly_max = 3; busy_min = 2; busy_max = 8;
      do_reset();
      s0 = n_starts;
      for (int i = 0; i < N; i++) add_byte(i, 8'hC0 + 8'(i), 1'b1);
      model_run();
      wait_idle("contention", 600);
      check_val("contention_starts", n_starts - s0, 3);
      check_val("contention_rr_ptr", dbg_rr, m_ptr);

      // packet lock with a 5-cycle stall between bytes
      do_reset();
      dly_max = 0; busy_min = 2; busy_max = 2; stall_fixed = 5;
      s0 = n_starts;
      add_byte(0, 8'hA1, 1'b0);
      add_byte(0, 8'hA2, 1'b0);
      add_byte(0, 8'hA3, 1'b1);
      add_byte(2, 8'hE7, 1'b1);
      model_run();
      wait_idle("lock", 600);
      check_val("lock_starts", n_starts - s0, 4);
      check_val("lock_rr_ptr", dbg_rr, m_ptr);
      stall_fixed = -1;

      // wrap-around: pointer at 2, requesters 0 and 2 valid
      dly_max = 3; busy_min = 2; busy_max = 8;
      do_reset();
      add_byte(1, 8'h11, 1'b1);
      model_run();
      wait_idle("wrap_setup", 400);
      check_val("wrap_setup_rr_ptr", dbg_rr, 2);
      add_byte(0, 8'h0F, 1'b1);
      add_byte(2, 8'h2F, 1'b1);
      model_run();
      wait_idle("wrap", 400);
      check_val("wrap_rr_ptr", dbg_rr, m_ptr);

      // randomized packets
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < N; i++) begin
            int np;
            np = int'($urandom_range(2, 0));
            for (int p = 0; p < np; p++) begin
               int len;
               len = int'($urandom_range(3, 1));
               for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1);
            end
         end
         model_run();
         wait_idle("random", 4000);
         check_val("random_rr_ptr", dbg_rr, m_ptr);
      end

      // timeout: UART never answers the first start
      do_reset();
      uart_on = 1'b0;
      add_byte(0, 8'hA5, 1'b1);
      add_byte(1, 8'h3C, 1'b1);
      model_run();
      seen = 1'b0;
      cnt  = 0;
      while (!seen && cnt < 50) begin
         @(negedge clk);
         cnt++;
         seen = tx_start;
      end
      check_val("timeout_start_seen", seen, 1);
      cnt = 0;
      while (!err_timeout && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check_val("timeout_latency", cnt, ACK_TO);
      check_val("timeout_grant", grant, 0);
      check_val("timeout_rr_ptr", dbg_rr, 1);
      uart_on = 1'b1;
      wait_idle("after_timeout", 600);
      check_val("timeout_sticky", err_timeout, 1);
      check_val("after_timeout_rr_ptr", dbg_rr, m_ptr);

      // reset for one cycle during WAIT_DONE
      dly_max = 0; busy_min = 10; busy_max = 10;
      add_byte(1, 8'h5A, 1'b0);
      add_byte(1, 8'hA5, 1'b1);
      model_run();
      seen = 1'b0;
      cnt  = 0;
      while (!seen && cnt < 60) begin
         @(negedge clk);
         cnt++;
         seen = (dbg_state == 3'(WAIT_DONE));
      end
      check_val("midrst_wait_done_seen", seen, 1);
      rst = 1'b0;
      clear_all();
      s0 = n_starts;
      @(negedge clk);
      rst = 1'b1;
      check_val("midrst_grant", grant, 0);
      check_val("midrst_req_ready", req_ready, 0);
      check_val("midrst_tx_start", tx_start, 0);
      check_val("midrst_tx_data", tx_data, 0);
      check_val("midrst_err", err_timeout, 0);
      check_val("midrst_rr_ptr", dbg_rr, 0);
      repeat (30) @(negedge clk);
      check_val("midrst_no_start", n_starts - s0, 0);
      cnt = 0;
      while (tx_busy && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      add_byte(2, 8'h77, 1'b1);
      model_run();
      wait_idle("after_midrst", 400);
      check_val("after_midrst_starts", n_starts - s0, 1);
      check_val("after_midrst_rr_ptr", dbg_rr, m_ptr);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
